// File: rtl/bch_pkg.sv
// Shared types and constants for the BCH encoder: code selection, code
// geometry, generator polynomials and LLR byte encoding.
// Build option: define BCH_ENC_SOFT_OUT_EN to emit +/-LLR_MAG soft bytes
// instead of 8'h00 / 8'hFF hard bytes.
package bch_pkg;

    localparam int         MAX_R   = 40;
    localparam int         MAX_M   = 10;
    localparam logic [7:0] LLR_MAG = 8'd127;

    typedef enum logic [1:0] {
        CODE_DFLT     = 2'd0,
        CODE_63_51    = 2'd1,
        CODE_255_239  = 2'd2,
        CODE_1023_983 = 2'd3
    } code_e;

    typedef enum logic [2:0] {
        S_IDLE, S_PAD, S_MSG, S_PAR, S_FLUSH
    } state_e;

`ifdef BCH_ENC_SOFT_OUT_EN
    localparam logic [7:0] BYTE_ZERO = LLR_MAG;
    localparam logic [7:0] BYTE_ONE  = ~LLR_MAG + 8'd1;
`else
    localparam logic [7:0] BYTE_ZERO = 8'h00;
    localparam logic [7:0] BYTE_ONE  = 8'hFF;
`endif

    // Primitive polynomials shared with the decoder (x^m term included)
    localparam logic [10:0] PRIM_M6  = 11'h043;  // x^6+x+1
    localparam logic [10:0] PRIM_M8  = 11'h11D;  // x^8+x^4+x^3+x^2+1
    localparam logic [10:0] PRIM_M10 = 11'h409;  // x^10+x^3+1

    // GF(2^m) multiply, elaboration-time only
    function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b,
                                          input int m, input logic [10:0] prim);
        logic [10:0] aa;
        logic [9:0]  p;
        aa = {1'b0, a};
        p  = '0;
        for (int i = 0; i < m; i++) begin
            if (b[i]) p = p ^ aa[9:0];
            aa = aa << 1;
            if (aa[m]) aa = aa ^ prim;
        end
        return p;
    endfunction

    // base^e by square-and-multiply
    function automatic logic [9:0] gf_pow(input logic [9:0] base, input int e,
                                          input int m, input logic [10:0] prim);
        logic [9:0] res;
        logic [9:0] b;
        res = 10'd1;
        b   = base;
        for (int i = 0; i < MAX_M; i++) begin
            if (e[i]) res = gf_mul(res, b, m, prim);
            b = gf_mul(b, b, m, prim);
        end
        return res;
    endfunction

    // Minimal polynomial of alpha^e: product of (x + beta) over its conjugacy class
    function automatic logic [MAX_R:0] min_poly(input int e, input int m, input logic [10:0] prim);
        logic [MAX_M:0][MAX_M-1:0] c;
        logic [MAX_R:0]            res;
        logic [9:0]                beta;
        int                        n;
        int                        cur;
        bit                        done;
        n    = (1 << m) - 1;
        c    = '0;
        c[0] = 10'd1;
        cur  = e;
        done = 1'b0;
        for (int j = 0; j < MAX_M; j++) begin
            if (!done) begin
                beta = gf_pow(10'd2, cur, m, prim);
                for (int d = MAX_M; d >= 1; d--)
                    c[d] = c[d-1] ^ gf_mul(beta, c[d], m, prim);
                c[0] = gf_mul(beta, c[0], m, prim);
                cur  = (cur * 2) % n;
                if (cur == e) done = 1'b1;
            end
        end
        res = '0;
        for (int d = 0; d <= MAX_M; d++) res[d] = c[d][0];
        return res;
    endfunction

    function automatic logic [MAX_R:0] poly_mul(input logic [MAX_R:0] a, input logic [MAX_R:0] b);
        logic [MAX_R:0] res;
        res = '0;
        for (int i = 0; i <= MAX_R; i++)
            if (b[i]) res = res ^ (a << i);
        return res;
    endfunction

    // g(x) = LCM of minimal polynomials of alpha, alpha^3, ..., alpha^(2t-1)
    function automatic logic [MAX_R:0] gen_poly(input int m, input logic [10:0] prim, input int t);
        logic [MAX_R:0] g;
        g = {{MAX_R{1'b0}}, 1'b1};
        for (int i = 0; i < t; i++) g = poly_mul(g, min_poly(2 * i + 1, m, prim));
        return g;
    endfunction

    // Low coefficients (x^r term dropped); the (63,51) one is 12'h539, (255,239) is 16'h6F63
    localparam logic [MAX_R:0]   G_FULL_63   = gen_poly(6,  PRIM_M6,  2);
    localparam logic [MAX_R:0]   G_FULL_255  = gen_poly(8,  PRIM_M8,  2);
    localparam logic [MAX_R:0]   G_FULL_1023 = gen_poly(10, PRIM_M10, 4);
    localparam logic [MAX_R-1:0] G_LOW_63    = G_FULL_63[MAX_R-1:0];
    localparam logic [MAX_R-1:0] G_LOW_255   = G_FULL_255[MAX_R-1:0];
    localparam logic [MAX_R-1:0] G_LOW_1023  = G_FULL_1023[MAX_R-1:0];

    function automatic code_e norm_code(input logic [1:0] c);
        return (c == 2'd0) ? CODE_1023_983 : code_e'(c);
    endfunction

    function automatic logic [5:0] code_r(input code_e c);
        case (c)
            CODE_63_51:   return 6'd12;
            CODE_255_239: return 6'd16;
            default:      return 6'd40;
        endcase
    endfunction

    // Highest frame position, N-1
    function automatic logic [9:0] code_last_pos(input code_e c);
        case (c)
            CODE_63_51:   return 10'd63;
            CODE_255_239: return 10'd255;
            default:      return 10'd1023;
        endcase
    endfunction

    function automatic logic [MAX_R-1:0] code_g(input code_e c);
        case (c)
            CODE_63_51:   return G_LOW_63;
            CODE_255_239: return G_LOW_255;
            default:      return G_LOW_1023;
        endcase
    endfunction

endpackage

// File: rtl/bch_enc_packer.sv
// Collects codeword bits (highest position first) into 64-bit words of
// eight LLR bytes behind a valid/ready output register. Raises o_stall when
// the eighth bit could not be placed because the previous word is unaccepted.
module bch_enc_packer
    import bch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_bit,
    input  logic        i_last,
    input  logic        i_out_ready,
    output logic        o_stall,
    output logic        o_out_valid,
    output logic [63:0] o_odata,
    output logic        o_out_last
);

    logic [6:0]  r_sh;
    logic [2:0]  r_cnt;
    logic        r_valid;
    logic        r_last;
    logic [63:0] r_data;
    logic [7:0]  w_bits;
    logic [63:0] w_word;
    logic        w_full;
    logic        w_load;

    assign w_bits  = {r_sh, i_bit};
    assign w_full  = (r_cnt == 3'd7);
    assign o_stall = w_full && r_valid && !i_out_ready;
    assign w_load  = i_push && w_full && !o_stall;

    // earliest bit lands in the top byte
    for (genvar j = 0; j < 8; j++) begin : g_byte
        assign w_word[8*j +: 8] = w_bits[j] ? BYTE_ONE : BYTE_ZERO;
    end

    // shift in bits; hand a full word to the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_push && !w_full) begin
                r_sh  <= {r_sh[5:0], i_bit};
                r_cnt <= r_cnt + 3'd1;
            end
            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
                r_last  <= i_last;
                r_cnt   <= '0;
            end else if (r_valid && i_out_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_valid;
    assign o_odata     = r_data;
    assign o_out_last  = r_last;

endmodule

// File: rtl/bch_encoder.sv
// Systematic serial BCH encoder: pad bit, k message bits, r parity bits
// from a generator-polynomial LFSR, packed into 64-bit LLR words.
// Build option: BCH_ENC_SOFT_OUT_EN selects soft +/-LLR_MAG output bytes.
module bch_encoder
    import bch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [1:0]  i_code,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_in_bit,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [63:0] o_odata,
    output logic        o_out_last,
    output logic        o_busy
);

    localparam logic [MAX_R-1:0] ONE_R = {{(MAX_R-1){1'b0}}, 1'b1};

    state_e           r_state;
    state_e           w_next;
    code_e            r_code;
    code_e            w_start_code;
    logic [9:0]       r_pos;
    logic [MAX_R-1:0] r_lfsr;
    logic [MAX_R-1:0] w_g;
    logic [MAX_R-1:0] w_mask;
    logic [MAX_R-1:0] w_lfsr_msg;
    logic [MAX_R-1:0] w_lfsr_par;
    logic [5:0]       w_r;
    logic             w_top;
    logic             w_fb;
    logic             w_stall;
    logic             w_push;
    logic             w_bit;
    logic             w_last;

    assign w_start_code = norm_code(i_code);
    assign w_r          = code_r(r_code);
    assign w_g          = code_g(r_code);
    assign w_mask       = (ONE_R << w_r) - ONE_R;
    assign w_top        = r_lfsr[w_r - 6'd1];
    assign w_fb         = i_in_bit ^ w_top;
    assign w_lfsr_msg   = ((r_lfsr << 1) ^ (w_fb ? w_g : '0)) & w_mask;
    assign w_lfsr_par   = (r_lfsr << 1) & w_mask;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next state; message ends at position r, parity at position 0
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_PAD;
            S_PAD:   if (w_push) w_next = S_MSG;
            S_MSG:   if (w_push && r_pos == {4'd0, w_r}) w_next = S_PAR;
            S_PAR:   if (w_push && r_pos == 10'd0) w_next = S_FLUSH;
            S_FLUSH: if (o_out_valid && i_out_ready && o_out_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // per-state handshake and bit selection into the packer
    always_comb begin
        o_in_ready = 1'b0;
        w_push     = 1'b0;
        w_bit      = 1'b0;
        w_last     = 1'b0;
        o_busy     = (r_state != S_IDLE);
        case (r_state)
            S_PAD: w_push = !w_stall;
            S_MSG: begin
                o_in_ready = !w_stall;
                w_push     = !w_stall && i_in_valid;
                w_bit      = i_in_bit;
            end
            S_PAR: begin
                w_push = !w_stall;
                w_bit  = w_top;
                w_last = (r_pos == 10'd0);
            end
            default: ;
        endcase
    end

    // frame setup, position countdown and parity LFSR
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= CODE_DFLT;
            r_pos  <= '0;
            r_lfsr <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_code <= w_start_code;
                r_pos  <= code_last_pos(w_start_code);
                r_lfsr <= '0;
            end
        end else if (w_push) begin
            if (r_pos != 10'd0) r_pos <= r_pos - 10'd1;
            if (r_state == S_MSG)      r_lfsr <= w_lfsr_msg;
            else if (r_state == S_PAR) r_lfsr <= w_lfsr_par;
        end
    end

    bch_enc_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_bit       (w_bit),
        .i_last      (w_last),
        .i_out_ready (i_out_ready),
        .o_stall     (w_stall),
        .o_out_valid (o_out_valid),
        .o_odata     (o_odata),
        .o_out_last  (o_out_last)
    );

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder: table of frames checked against a
// polynomial-division reference and GF(2^m) syndromes, plus reset sequences.
module tb_bch_encoder;
    import bch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  code;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] odata;
    logic        out_last;
    logic        busy;

    int checks   = 0;
    int failures = 0;

`ifdef BCH_ENC_SOFT_OUT_EN
    localparam logic [7:0] EXP_B0 = 8'h7F;
    localparam logic [7:0] EXP_B1 = 8'h81;
`else
    localparam logic [7:0] EXP_B0 = 8'h00;
    localparam logic [7:0] EXP_B1 = 8'hFF;
`endif

    always #5 clk = ~clk;

    bch_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .i_code      (code),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_bit    (in_bit),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_odata     (odata),
        .o_out_last  (out_last),
        .o_busy      (busy)
    );

    typedef struct {
        logic [1:0] code;
        int         pat;       // 0 zeros, 1 only last bit set, 2 random, 3 all ones
        int         rdy_pct;
        bit         restart;   // pulse start (code 1) mid-frame
        int         exp_words;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // number of nonzero syndromes S_1..S_2t of the codeword c(alpha^j)
    function automatic int syn_nonzero(input logic [1023:0] cw, input int mm);
        int ex [0:1022];
        int n1;
        int t;
        int prim;
        int x;
        int s;
        int cnt;
        n1   = (1 << mm) - 1;
        t    = (mm == 10) ? 4 : 2;
        prim = (mm == 6) ? 'h43 : (mm == 8) ? 'h11D : 'h409;
        ex[0] = 1;
        for (int i = 1; i < n1; i++) begin
            x = ex[i-1] << 1;
            if ((x & (1 << mm)) != 0) x = x ^ prim;
            ex[i] = x;
        end
        cnt = 0;
        for (int j = 1; j <= 2 * t; j++) begin
            s = 0;
            for (int p = 0; p < n1; p++)
                if (cw[p]) s = s ^ ex[(j * p) % n1];
            if (s != 0) cnt++;
        end
        return cnt;
    endfunction

    task automatic run_frame(input vec_t v, output logic [1023:0] dut_cw);
        int             c, mm, k, r, nn, nwords;
        int             idx, nw, stall_bad, last_bad, byte_bad;
        bit             done;
        logic [1023:0]  msg_b;
        logic [1023:0]  ref_cw;
        logic [1023:0]  d;
        logic [MAX_R:0] gfull;
        logic [63:0]    words [0:255];
        logic [7:0]     actb, expb;
        int             pos;

        c = (v.code == 2'd0) ? 3 : int'(v.code);
        case (c)
            1:       begin mm = 6;  k = 51;  r = 12; end
            2:       begin mm = 8;  k = 239; r = 16; end
            default: begin mm = 10; k = 983; r = 40; end
        endcase
        nn     = 1 << mm;
        nwords = nn / 8;
        gfull  = ({{MAX_R{1'b0}}, 1'b1} << r) | {1'b0, code_g(code_e'(c))};

        msg_b = '0;
        for (int i = 0; i < k; i++)
            case (v.pat)
                0:       msg_b[i] = 1'b0;
                1:       msg_b[i] = (i == k - 1);
                2:       msg_b[i] = 1'($urandom_range(1));
                default: msg_b[i] = 1'b1;
            endcase

        // reference: c(x) = m(x) x^r + (m(x) x^r mod g(x)), pad at N-1 is 0
        ref_cw = '0;
        for (int i = 0; i < k; i++) ref_cw[nn-2-i] = msg_b[i];
        d = ref_cw;
        for (int p = nn - 2; p >= r; p--)
            if (d[p])
                for (int q = 0; q <= r; q++) d[p-r+q] = d[p-r+q] ^ gfull[q];
        for (int q = 0; q < r; q++) ref_cw[q] = d[q];

        @(negedge clk);
        start    = 1'b1;
        code     = v.code;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        code  = 2'($urandom_range(3));

        idx = 0; nw = 0; stall_bad = 0; last_bad = 0; done = 1'b0;
        for (int cyc = 0; cyc < 4 * nn + 200 && !done; cyc++) begin
            out_ready = ($urandom_range(99) < v.rdy_pct);
            in_valid  = ($urandom_range(3) != 0);
            in_bit    = (idx < k) ? msg_b[idx] : 1'($urandom_range(1));
            start     = v.restart && (cyc == 40);
            if (start) code = 2'd1;
            #1;
            if (idx > 0 && idx < k && !in_ready && !(out_valid && !out_ready)) stall_bad++;
            if (in_ready && in_valid) idx++;
            if (out_valid && out_ready) begin
                if (nw < 256) words[nw] = odata;
                if (out_last != (nw == nwords - 1)) last_bad++;
                nw++;
                if (out_last) done = 1'b1;
            end
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!done) $display("FAIL frame_timeout: got %0d words expected %0d", nw, nwords);

        chk("word_count", 64'(nw), 64'(v.exp_words));
        chk("msg_bits_taken", 64'(idx), 64'(k));
        chk("last_flag_errs", 64'(last_bad), 64'd0);
        chk("stall_rule_errs", 64'(stall_bad), 64'd0);

        dut_cw   = '0;
        byte_bad = 0;
        for (int w = 0; w < nw && w < nwords; w++)
            for (int j = 0; j < 8; j++) begin
                pos  = nn - 1 - 8 * w - j;
                actb = words[w][63-8*j -: 8];
                expb = ref_cw[pos] ? EXP_B1 : EXP_B0;
                dut_cw[pos] = actb[7];
                if (actb !== expb) begin
                    if (byte_bad == 0)
                        $display("  first byte diff at word %0d byte %0d: got %0h want %0h", w, j, actb, expb);
                    byte_bad++;
                end
            end
        chk("data_byte_errs", 64'(byte_bad), 64'd0);
        chk("pad_bit", {63'd0, dut_cw[nn-1]}, 64'd0);
        chk("syndromes_nonzero", 64'(syn_nonzero(dut_cw, mm)), 64'd0);
        chk("busy_after_frame", {63'd0, busy}, 64'd0);
        chk("out_valid_after_frame", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl [6];
        logic [1023:0] cw;
        int            idx;

        tbl[0] = '{code: 2'd1, pat: 0, rdy_pct: 100, restart: 1'b0, exp_words: 8};
        tbl[1] = '{code: 2'd1, pat: 1, rdy_pct: 100, restart: 1'b0, exp_words: 8};
        tbl[2] = '{code: 2'd3, pat: 2, rdy_pct: 100, restart: 1'b0, exp_words: 128};
        tbl[3] = '{code: 2'd2, pat: 2, rdy_pct: 50,  restart: 1'b0, exp_words: 32};
        tbl[4] = '{code: 2'd0, pat: 2, rdy_pct: 70,  restart: 1'b1, exp_words: 128};
        tbl[5] = '{code: 2'd2, pat: 3, rdy_pct: 30,  restart: 1'b0, exp_words: 32};

        rst = 1'b1; start = 1'b0; code = 2'd0;
        in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_odata",     odata,              64'd0);
        chk("rst_out_last",  {63'd0, out_last},  64'd0);
        chk("rst_busy",      {63'd0, busy},      64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], cw);
            if (i == 1) begin
                chk("g63_parity", {52'd0, cw[11:0]}, 64'h539);
                chk("g63_index12", {63'd0, cw[12]}, 64'd1);
            end
        end

        // reset at message bit 100 of a (1023,983) frame
        @(negedge clk);
        start = 1'b1; code = 2'd3; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 400 && idx < 100; cyc++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(1));
            #1;
            if (in_ready) idx++;
            @(negedge clk);
        end
        chk("reached_bit100", 64'(idx), 64'd100);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_odata",     odata,              64'd0);
        chk("midrst_out_last",  {63'd0, out_last},  64'd0);
        chk("midrst_busy",      {63'd0, busy},      64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        run_frame('{code: 2'd1, pat: 2, rdy_pct: 80, restart: 1'b0, exp_words: 8}, cw);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
